// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and defaults for the EX-stage
// multiply/divide HI/LO control block.
package muldiv_pkg;

   localparam logic [2:0] MULDIV_OP_NONE  = 3'd0;
   localparam logic [2:0] MULDIV_OP_DIV   = 3'd1;
   localparam logic [2:0] MULDIV_OP_DIVU  = 3'd2;
   localparam logic [2:0] MULDIV_OP_MULT  = 3'd3;
   localparam logic [2:0] MULDIV_OP_MULTU = 3'd4;
   localparam logic [2:0] MULDIV_OP_MTHI  = 3'd5;
   localparam logic [2:0] MULDIV_OP_MTLO  = 3'd6;

   localparam logic [5:0] DIV_TIMEOUT_DEF = 6'd40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_mult32.sv
// Combinational 32x32->64 multiplier, signed or unsigned.
module muldiv_mult32 (
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);

   logic [63:0] a_ext;
   logic [63:0] b_ext;

   // Low 64 bits of the sign-extended product equal the signed result.
   always_comb begin
      a_ext = {{32{is_signed & a[31]}}, a};
      b_ext = {{32{is_signed & b[31]}}, b};
      p     = a_ext * b_ext;
   end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage HI/LO owner: issues divides to the iterative divider,
// stalls until Ready, and handles flush, drain and watchdog retry.
module muldiv_hilo_ctrl
   import muldiv_pkg::*;
#(
   parameter logic [5:0] DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_start,
   output logic        div_annul,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [63:0] div_result,
   input  logic        div_ready,
   output logic        div_timeout
);

   md_state_e   state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
   logic        div_start_q, div_start_d;
   logic        div_annul_q, div_annul_d;
   logic        div_signed_q, div_signed_d;
   logic        div_timeout_q, div_timeout_d;
   logic [5:0]  wdog_q, wdog_d;
   logic        stall_c;
   logic        live, div_req;
   logic [63:0] prod;

   muldiv_mult32 u_mult (
      .is_signed (op == MULDIV_OP_MULT),
      .a         (rs_val),
      .b         (rt_val),
      .p         (prod)
   );

   always_comb begin
      live    = op_valid & ~flush;
      div_req = live & ((op == MULDIV_OP_DIV) | (op == MULDIV_OP_DIVU));
   end

   always_comb begin
      state_d       = state_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      div_a_d       = div_a_q;
      div_b_d       = div_b_q;
      div_start_d   = div_start_q;
      div_signed_d  = div_signed_q;
      div_annul_d   = 1'b0;
      div_timeout_d = 1'b0;
      wdog_d        = wdog_q;
      stall_c       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (div_req) begin
               div_a_d      = rs_val;
               div_b_d      = rt_val;
               div_signed_d = (op == MULDIV_OP_DIV);
               div_start_d  = 1'b1;
               wdog_d       = '0;
               state_d      = ST_BUSY;
               stall_c      = 1'b1;
            end
         end
         ST_BUSY: begin
            stall_c = ~div_ready;
            wdog_d  = wdog_q + 6'd1;
            // Flush wins over a same-cycle Ready: the result is dropped.
            if (flush) begin
               div_annul_d = 1'b1;
               div_start_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (div_ready) begin
               hi_d        = div_result[63:32];
               lo_d        = div_result[31:0];
               div_start_d = 1'b0;
               state_d     = ST_DRAIN;
            end else if (wdog_q == DIV_TIMEOUT - 6'd1) begin
               div_annul_d   = 1'b1;
               div_timeout_d = 1'b1;
               div_start_d   = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            stall_c = div_req;
            if (!div_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            div_start_d = 1'b0;
         end
      endcase
      if (live && state_q != ST_BUSY) begin
         case (op)
            MULDIV_OP_MULT,
            MULDIV_OP_MULTU: {hi_d, lo_d} = prod;
            MULDIV_OP_MTHI:  hi_d = rs_val;
            MULDIV_OP_MTLO:  lo_d = rs_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hi_q          <= '0;
         lo_q          <= '0;
         div_a_q       <= '0;
         div_b_q       <= '0;
         div_start_q   <= 1'b0;
         div_annul_q   <= 1'b0;
         div_signed_q  <= 1'b0;
         div_timeout_q <= 1'b0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         div_a_q       <= div_a_d;
         div_b_q       <= div_b_d;
         div_start_q   <= div_start_d;
         div_annul_q   <= div_annul_d;
         div_signed_q  <= div_signed_d;
         div_timeout_q <= div_timeout_d;
         wdog_q        <= wdog_d;
      end
   end

   assign stall       = stall_c & ~rst;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_start   = div_start_q;
   assign div_annul   = div_annul_q;
   assign div_signed  = div_signed_q;
   assign div_a       = div_a_q;
   assign div_b       = div_b_q;
   assign div_timeout = div_timeout_q;

endmodule
